// File: rtl/hmem_responder_pkg.sv
// Shared memory-port types for the torrence cache and its backing responder.
// Holds the request enums, the responder FSM state type and lane/alignment helpers.
package torrence_params;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } hmem_state_e;

    localparam int HMEM_DEFAULT_LATENCY = 4;

    // Byte lanes covered by an access of the given size, before shifting to the address.
    function automatic logic [3:0] size_lanes(input memory_operation_size_e size);
        case (size)
            BYTE:    size_lanes = 4'b0001;
            HALF:    size_lanes = 4'b0011;
            WORD:    size_lanes = 4'b1111;
            default: size_lanes = 4'b0000;
        endcase
    endfunction

    // The unused size encoding is reported as misaligned so it always errors.
    function automatic logic is_misaligned(input memory_operation_size_e size, input logic [1:0] low);
        case (size)
            BYTE:    is_misaligned = 1'b0;
            HALF:    is_misaligned = low[0];
            WORD:    is_misaligned = |low;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/hmem_storage.sv
// Word-organized backing array: one shared address, per-byte-lane write enable,
// combinational read. Contents are deliberately not reset.
module hmem_storage #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    byte_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [WORDS];

    // Byte-lane masked write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/hmem_responder.sv
// Fixed-latency backing-memory responder for the cache's higher-memory port.
// Optional read/write completion counters are enabled with HMEM_PERF_COUNTERS_EN.
module hmem_responder
    import torrence_params::*;
#(
    parameter int              XLEN         = 32,
    parameter int              MEM_SIZE     = 4096,
    parameter int              LATENCY      = HMEM_DEFAULT_LATENCY,
    parameter logic [XLEN-1:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  memory_operation_e      req_operation,
    input  memory_operation_size_e req_size,
    input  logic [XLEN-1:0]        req_address,
    input  logic [XLEN-1:0]        req_store_word,
    output logic [XLEN-1:0]        req_loaded_word,
    output logic                   req_fulfilled,
    output logic                   req_error,
    output logic [XLEN-1:0]        read_count,
    output logic [XLEN-1:0]        write_count
);

    localparam int WORDS = MEM_SIZE / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    hmem_state_e            state_r;
    logic [CW-1:0]          count_r;
    memory_operation_e      op_r;
    memory_operation_size_e size_r;
    logic [XLEN-1:0]        addr_r;
    logic [XLEN-1:0]        wdata_r;
    logic                   fulfilled_r;
    logic                   error_r;
    logic [XLEN-1:0]        loaded_r;

    logic [XLEN-1:0] offset_s;
    logic            err_s;
    logic [3:0]      lanes_s;
    logic [3:0]      byte_en_s;
    logic [31:0]     rdata_s;
    logic [31:0]     rshift_s;
    logic [31:0]     load_s;

    assign offset_s = addr_r - BASE_ADDRESS;
    assign err_s    = (addr_r < BASE_ADDRESS) || (offset_s >= XLEN'(MEM_SIZE))
                      || is_misaligned(size_r, addr_r[1:0]);
    assign lanes_s  = size_lanes(size_r) << addr_r[1:0];
    assign rshift_s = rdata_s >> {addr_r[1:0], 3'b000};

    // Storage is only written on the RESPOND cycle of a legal store.
    always_comb begin
        byte_en_s = 4'b0000;
        if ((state_r == RESPOND) && (op_r == STORE) && !err_s) begin
            byte_en_s = lanes_s;
        end else begin
            byte_en_s = 4'b0000;
        end
    end

    // Right-justify the addressed lanes and zero the rest.
    always_comb begin
        load_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (size_lanes(size_r)[i]) begin
                load_s[8*i +: 8] = rshift_s[8*i +: 8];
            end else begin
                load_s[8*i +: 8] = 8'h00;
            end
        end
    end

    hmem_storage #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .byte_en (byte_en_s),
        .addr    (offset_s[AW+1:2]),
        .wdata   (wdata_r << {addr_r[1:0], 3'b000}),
        .rdata   (rdata_s)
    );

    // Request FSM: latch in IDLE, count down in BUSY, complete in RESPOND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= '0;
            op_r        <= LOAD;
            size_r      <= BYTE;
            addr_r      <= '0;
            wdata_r     <= '0;
            fulfilled_r <= 1'b0;
            error_r     <= 1'b0;
            loaded_r    <= '0;
        end else begin
            fulfilled_r <= 1'b0;
            error_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r    <= req_operation;
                        size_r  <= req_size;
                        addr_r  <= req_address;
                        wdata_r <= req_store_word;
                        count_r <= CW'(LATENCY - 1);
                        state_r <= (LATENCY == 1) ? RESPOND : BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                // Leaving BUSY as the count reaches zero puts the pulse LATENCY edges after acceptance.
                BUSY: begin
                    count_r <= count_r - CW'(1);
                    if (count_r == CW'(1)) begin
                        state_r <= RESPOND;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                RESPOND: begin
                    fulfilled_r <= 1'b1;
                    error_r     <= err_s;
                    if (err_s) begin
                        loaded_r <= '0;
                    end else if (op_r == LOAD) begin
                        loaded_r <= load_s;
                    end else begin
                        loaded_r <= loaded_r;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_fulfilled   = fulfilled_r;
    assign req_error       = error_r;
    assign req_loaded_word = loaded_r;

`ifdef HMEM_PERF_COUNTERS_EN
    logic [XLEN-1:0] read_count_r;
    logic [XLEN-1:0] write_count_r;

    // Count legal completions; both counters wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_count_r  <= '0;
            write_count_r <= '0;
        end else if ((state_r == RESPOND) && !err_s) begin
            if (op_r == LOAD) begin
                read_count_r <= read_count_r + XLEN'(1);
            end else begin
                write_count_r <= write_count_r + XLEN'(1);
            end
        end else begin
            read_count_r  <= read_count_r;
            write_count_r <= write_count_r;
        end
    end

    assign read_count  = read_count_r;
    assign write_count = write_count_r;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: doc/hmem_responder.md
Name: hmem_responder

Overview:
- Backing-memory responder on the requester side of the cache's higher-memory port. It services the load and store word requests a cache issues during refill and writeback.
- Byte-addressed storage array with a programmable fixed response latency, handling byte, half and word sizes.
- Used as the terminal memory under an L1 in simulation and FPGA builds. It also acts as the reference responder for cache verification.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- MEM_SIZE, 4096, storage size in bytes; must be a power of two and divisible by 4.
- LATENCY, 4, cycles from request acceptance to req_fulfilled; must be ≥1.
- BASE_ADDRESS, 0, first byte address served; must be aligned to MEM_SIZE.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; held by requester until req_fulfilled.
- req_operation  input  memory_operation_e  LOAD or STORE.
- req_size  input  memory_operation_size_e  BYTE, HALF or WORD.
- req_address  input  XLEN  byte address.
- req_store_word  input  XLEN  store data, right-justified.
- req_loaded_word  output  XLEN  load data, right-justified and zero-extended; valid while req_fulfilled.
- req_fulfilled  output  1  one-cycle completion pulse.
- req_error  output  1  qualifies req_fulfilled: the access was misaligned or out of range.
- read_count  output  XLEN  completed loads (optional feature).
- write_count  output  XLEN  completed stores (optional feature).

Behaviour:
- FSM states: IDLE, BUSY, RESPOND.
- Reset (reset=0, asynchronous): state goes to IDLE. req_fulfilled, req_error, req_loaded_word, latency counter and perf counters all go to 0. Storage contents are not reset.
- IDLE, with req_valid=1 on edge T:
  - Latch operation, size, address and store word.
  - Load latency counter with LATENCY-1.
  - Go to BUSY, or directly to RESPOND if LATENCY=1.
- BUSY: decrement each cycle. At count 0, go to RESPOND.
- RESPOND (one cycle):
  - req_fulfilled=1.
  - Perform the store, or drive load data.
  - Next state is IDLE.
  - req_fulfilled first rises at edge T+LATENCY.
- Requester changes to its next request on the cycle after req_fulfilled. The responder is in IDLE that cycle and accepts it, giving a minimum issue interval of LATENCY+1 cycles.
- Inputs are ignored outside IDLE. Changes to req_* while BUSY have no effect because the latched copy is used.
- Alignment rule: HALF requires addr[0]=0; WORD requires addr[1:0]=0.
- Range rule: BASE_ADDRESS ≤ addr < BASE_ADDRESS+MEM_SIZE.
- On a rule violation: req_error=1 with req_fulfilled, no storage write, req_loaded_word=0.
- Store: write only the addressed byte lanes, little-endian. BYTE uses store_word[7:0]; HALF uses [15:0].
- Load: BYTE and HALF results are zero-extended into req_loaded_word.
- req_loaded_word holds its last value outside RESPOND. req_error is 0 outside RESPOND.
- Reset asserted while BUSY: the in-flight request is dropped with no write and no fulfilled pulse.
- req_valid deasserted mid-BUSY: the request still completes; the requester must ignore the pulse.

Optional Feature:
- Macro: HMEM_PERF_COUNTERS_EN.
- Defined: read_count and write_count increment on each non-error LOAD or STORE completion. They wrap at 2^XLEN and are reset to 0.
- Undefined: no counter flops; both ports are tied to 0.

Decomposition:
- torrence_params package holds memory_operation_e (LOAD, STORE) and memory_operation_size_e (BYTE=0, HALF=1, WORD=2), which the cache already uses.
- The same package also holds the hmem_state_e FSM enum and the HMEM_DEFAULT_LATENCY constant.
- One sub-module: hmem_storage. It is a word-organized array with 4-bit byte-lane write enable, a single read port and a combinational read.
- The FSM, latency counter, alignment and range check stay in hmem_responder.

Test Plan:
- Word store then load: with LATENCY=4, store 0xDEADBEEF to 0x40, then load 0x40. Each req_fulfilled arrives exactly 4 edges after acceptance; the load returns 0xDEADBEEF.
- Byte lanes: write word 0x11223344 to 0x80, then BYTE store 0xAA to 0x81 and HALF store 0xBEEF to 0x82. Word load at 0x80 returns 0xBEEFAA44; BYTE load at 0x83 returns 0x000000BE.
- Error cases: HALF load at 0x41 gives req_error=1 with req_fulfilled and data 0. WORD store at MEM_SIZE gives req_error=1, and a following load at 0x0 shows its contents unchanged.
- Back-to-back refill: 8 consecutive WORD loads with addresses stepping down 0x1C to 0x00, each issued the cycle after fulfilled. Exactly 8 pulses, spaced LATENCY+1 apart.
- Reset mid-op: assert reset 2 cycles into a STORE of 0x12345678 to 0x10. No pulse occurs, and a later load of 0x10 returns the previous contents.
- LATENCY=1 with HMEM_PERF_COUNTERS_EN defined: fulfilled arrives the edge after acceptance. After 3 loads, 2 stores and 1 error, read_count=3 and write_count=2.
